// File: rtl/motor_fault_monitor.sv
// ---------------------------------------------------------------------------
// motor_fault_monitor
//
// Synthetic induction-motor condition monitor. A phase counter walks a
// 64-entry sine table; the selected operating mode shapes that sine into a
// per-mode current waveform, which is registered as the observable sample.
// Every clock the current sample is squared and accumulated. After 64
// samples the mean square is latched as the feature, and a threshold
// classifier turns the feature into a fault code.
//
// Ports
//   clk     in   1        system clock, all state updates on the rising edge
//   rst     in   1        asynchronous active-high reset
//   mode    in   2        requested condition: 00 healthy, 01 bearing,
//                         10 rotor, 11 stator
//   signal  out  16 s     registered synthetic current sample
//   rms     out  32 u     registered mean square of the last full window
//   fault   out  2        fault code derived combinationally from rms
// ---------------------------------------------------------------------------
module motor_fault_monitor #(
    parameter int T_BEARING = 589824,
    parameter int T_ROTOR   = 917504,
    parameter int T_STATOR  = 1638400
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    output logic signed [15:0] signal,
    output logic [31:0]        rms,
    output logic [1:0]         fault
);

    localparam logic [31:0] TH_BEARING = 32'(T_BEARING);
    localparam logic [31:0] TH_ROTOR   = 32'(T_ROTOR);
    localparam logic [31:0] TH_STATOR  = 32'(T_STATOR);

    // -----------------------------------------------------------------------
    // Sine table: round(1024 * sin(2*pi*k/64)). Read combinationally because
    // the result is captured by the signal register in the same cycle.
    // -----------------------------------------------------------------------
    function automatic logic signed [15:0] sine_lut(input logic [5:0] k);
        logic signed [15:0] v;
        case (k)
            6'd0:  v = 16'sd0;
            6'd1:  v = 16'sd100;
            6'd2:  v = 16'sd200;
            6'd3:  v = 16'sd297;
            6'd4:  v = 16'sd392;
            6'd5:  v = 16'sd483;
            6'd6:  v = 16'sd569;
            6'd7:  v = 16'sd650;
            6'd8:  v = 16'sd724;
            6'd9:  v = 16'sd792;
            6'd10: v = 16'sd851;
            6'd11: v = 16'sd903;
            6'd12: v = 16'sd946;
            6'd13: v = 16'sd980;
            6'd14: v = 16'sd1004;
            6'd15: v = 16'sd1019;
            6'd16: v = 16'sd1024;
            6'd17: v = 16'sd1019;
            6'd18: v = 16'sd1004;
            6'd19: v = 16'sd980;
            6'd20: v = 16'sd946;
            6'd21: v = 16'sd903;
            6'd22: v = 16'sd851;
            6'd23: v = 16'sd792;
            6'd24: v = 16'sd724;
            6'd25: v = 16'sd650;
            6'd26: v = 16'sd569;
            6'd27: v = 16'sd483;
            6'd28: v = 16'sd392;
            6'd29: v = 16'sd297;
            6'd30: v = 16'sd200;
            6'd31: v = 16'sd100;
            6'd32: v = 16'sd0;
            6'd33: v = -16'sd100;
            6'd34: v = -16'sd200;
            6'd35: v = -16'sd297;
            6'd36: v = -16'sd392;
            6'd37: v = -16'sd483;
            6'd38: v = -16'sd569;
            6'd39: v = -16'sd650;
            6'd40: v = -16'sd724;
            6'd41: v = -16'sd792;
            6'd42: v = -16'sd851;
            6'd43: v = -16'sd903;
            6'd44: v = -16'sd946;
            6'd45: v = -16'sd980;
            6'd46: v = -16'sd1004;
            6'd47: v = -16'sd1019;
            6'd48: v = -16'sd1024;
            6'd49: v = -16'sd1019;
            6'd50: v = -16'sd1004;
            6'd51: v = -16'sd980;
            6'd52: v = -16'sd946;
            6'd53: v = -16'sd903;
            6'd54: v = -16'sd851;
            6'd55: v = -16'sd792;
            6'd56: v = -16'sd724;
            6'd57: v = -16'sd650;
            6'd58: v = -16'sd569;
            6'd59: v = -16'sd483;
            6'd60: v = -16'sd392;
            6'd61: v = -16'sd297;
            6'd62: v = -16'sd200;
            6'd63: v = -16'sd100;
            default: v = 16'sd0;
        endcase
        return v;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [5:0]         phase_reg;
    logic signed [15:0] signal_reg;
    logic [31:0]        acc_reg;
    logic [5:0]         count_reg;
    logic [31:0]        rms_reg;

    // -----------------------------------------------------------------------
    // Waveform shaping
    // -----------------------------------------------------------------------
    logic signed [15:0] base_sample;
    logic signed [15:0] harm_sample;
    logic signed [15:0] wave_next;

    // (8p) mod 64 is simply the low three phase bits moved up by three.
    assign base_sample = sine_lut(phase_reg);
    assign harm_sample = sine_lut({phase_reg[2:0], 3'b000});

    always_comb begin
        wave_next = base_sample;
        case (mode)
            2'b00:   wave_next = base_sample;
            2'b01:   wave_next = base_sample + (harm_sample >>> 1);
            2'b10:   wave_next = base_sample + (base_sample >>> 1);
            default: wave_next = base_sample <<< 1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Mean-square feature
    // -----------------------------------------------------------------------
    logic signed [31:0] signal_ext;
    logic signed [31:0] sq_signed;
    logic [31:0]        sq;
    logic [31:0]        acc_sum;
    logic               window_end;
    logic [31:0]        rms_next;

    // Sign-extend before squaring so the product is formed at full width;
    // a square is never negative, so the unsigned view is exact.
    assign signal_ext = 32'(signal_reg);
    assign sq_signed  = signal_ext * signal_ext;
    assign sq         = $unsigned(sq_signed);
    assign acc_sum    = acc_reg + sq;
    assign window_end = (count_reg == 6'd63);
    assign rms_next   = {6'd0, acc_sum[31:6]};

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg  <= 6'd0;
            signal_reg <= 16'sd0;
        end else begin
            phase_reg  <= phase_reg + 6'd1;
            signal_reg <= wave_next;
        end
    end

    // The sample squared here is the value already sitting in signal_reg,
    // so the first window after reset includes the reset zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= 32'd0;
            count_reg <= 6'd0;
            rms_reg   <= 32'd0;
        end else begin
            count_reg <= count_reg + 6'd1;
            if (window_end) begin
                rms_reg <= rms_next;
                acc_reg <= 32'd0;
            end else begin
                acc_reg <= acc_sum;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Classifier: highest threshold reached wins.
    // -----------------------------------------------------------------------
    logic [1:0] fault_code;

    always_comb begin
        fault_code = 2'b00;
        if (rms_reg >= TH_STATOR) begin
            fault_code = 2'b11;
        end else if (rms_reg >= TH_ROTOR) begin
            fault_code = 2'b10;
        end else if (rms_reg >= TH_BEARING) begin
            fault_code = 2'b01;
        end
    end

    assign signal = signal_reg;
    assign rms    = rms_reg;
    assign fault  = fault_code;

endmodule

// File: tb/tb_motor_fault_monitor.sv
// ---------------------------------------------------------------------------
// tb_motor_fault_monitor
//
// Drives motor_fault_monitor through reset, each operating mode, a mode
// sequence and a mid-window asynchronous reset. A behavioural model built
// from the sine formula, the per-mode waveform rules and a 64-sample window
// of squares predicts signal, rms and fault every clock.
// ---------------------------------------------------------------------------
module tb_motor_fault_monitor;

    localparam int T_BEARING = 589824;
    localparam int T_ROTOR   = 917504;
    localparam int T_STATOR  = 1638400;

    logic               clk;
    logic               rst;
    logic [1:0]         mode;
    logic signed [15:0] sig_o;
    logic [31:0]        rms_o;
    logic [1:0]         fault_o;

    int vectors;
    int miscompares;

    motor_fault_monitor #(
        .T_BEARING(T_BEARING),
        .T_ROTOR  (T_ROTOR),
        .T_STATOR (T_STATOR)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .signal(sig_o),
        .rms   (rms_o),
        .fault (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int     lut [64];
    int     n;              // rising edges since reset release
    int     m_sig;
    longint m_rms;
    logic [1:0] m_fault;
    longint win [$];        // squares of samples in the current window

    function automatic int wave(input logic [1:0] m, input int k);
        int b;
        b = lut[k];
        case (m)
            2'd0:    return b;
            2'd1:    return b + (lut[(8 * k) % 64] >>> 1);
            2'd2:    return b + (b >>> 1);
            default: return 2 * b;
        endcase
    endfunction

    function automatic logic [1:0] classify(input longint r);
        if (r >= T_STATOR)  return 2'b11;
        if (r >= T_ROTOR)   return 2'b10;
        if (r >= T_BEARING) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        n       = 0;
        m_sig   = 0;
        m_rms   = 0;
        m_fault = 2'b00;
        win.delete();
    endtask

    // Advance one clock with mode m held across the edge, then update the
    // model; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic [1:0] m);
        longint s;
        mode = m;
        @(posedge clk);
        #1;
        win.push_back(longint'(m_sig) * longint'(m_sig));
        n     = n + 1;
        m_sig = wave(m, (n - 1) % 64);
        if (win.size() == 64) begin
            s = 0;
            foreach (win[i]) s += win[i];
            m_rms = s / 64;
            win.delete();
        end
        m_fault = classify(m_rms);
    endtask

    function automatic bit within2(input longint v, input longint nom);
        return (v * 100 >= nom * 98) && (v * 100 <= nom * 102);
    endfunction

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst  = 1'b1;
        mode = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (sig_o !== 16'sd0 || rms_o !== 32'd0 || fault_o !== 2'b00) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d signal=%0d rms=%0d fault=%0d required 0/0/0",
                         c, sig_o, rms_o, fault_o);
            end else
                $display("reset_hold cyc=%0d ok", c);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_healthy();
        for (int i = 0; i < 200; i++) begin
            step(2'b00);
            vectors++;
            if (sig_o !== 16'(m_sig) || rms_o !== 32'(m_rms) || fault_o !== m_fault) begin
                miscompares++;
                $display("FAIL healthy n=%0d signal=%0d/%0d rms=%0d/%0d fault=%0d/%0d",
                         n, sig_o, m_sig, rms_o, m_rms, fault_o, m_fault);
            end
            if (n == 17) begin
                vectors++;
                if (sig_o !== 16'sd1024) begin
                    miscompares++;
                    $display("FAIL healthy_peak signal=%0d required 1024", sig_o);
                end else
                    $display("healthy_peak n=17 signal=%0d", sig_o);
            end
            if (n == 64) begin
                vectors++;
                if (!within2(longint'(rms_o), 524288) || fault_o !== 2'b00) begin
                    miscompares++;
                    $display("FAIL healthy_first_window rms=%0d fault=%0d required ~524288/0",
                             rms_o, fault_o);
                end else
                    $display("healthy_first_window rms=%0d fault=%0d", rms_o, fault_o);
            end
        end
    endtask

    task automatic test_mode(input logic [1:0] m, input longint nominal,
                             input int peak, input int trough);
        int hi, lo;
        hi = -100000;
        lo = 100000;
        for (int i = 1; i <= 200; i++) begin
            step(m);
            vectors++;
            if (sig_o !== 16'(m_sig) || rms_o !== 32'(m_rms) || fault_o !== m_fault) begin
                miscompares++;
                $display("FAIL mode%0d n=%0d signal=%0d/%0d rms=%0d/%0d fault=%0d/%0d",
                         m, n, sig_o, m_sig, rms_o, m_rms, fault_o, m_fault);
            end
            if (int'(sig_o) > hi) hi = int'(sig_o);
            if (int'(sig_o) < lo) lo = int'(sig_o);
            if (i >= 129) begin
                vectors++;
                if (!within2(longint'(rms_o), nominal) || fault_o !== m) begin
                    miscompares++;
                    $display("FAIL mode%0d_steady i=%0d rms=%0d fault=%0d required ~%0d/%0d",
                             m, i, rms_o, fault_o, nominal, m);
                end
            end
        end
        $display("mode%0d done rms=%0d fault=%0d peak=%0d trough=%0d", m, rms_o, fault_o, hi, lo);
        if (peak != 0) begin
            vectors++;
            if (hi != peak || lo != trough) begin
                miscompares++;
                $display("FAIL mode%0d_extremes peak=%0d trough=%0d required %0d/%0d",
                         m, hi, lo, peak, trough);
            end
        end
    endtask

    task automatic test_sequence();
        logic [1:0] prev;
        prev = mode;
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 200; i++) begin
                step(2'(m));
                vectors++;
                if (sig_o !== 16'(m_sig) || rms_o !== 32'(m_rms) || fault_o !== m_fault ||
                    (fault_o < prev && fault_o < 2'(m)) ||
                    (fault_o > prev && fault_o > 2'(m))) begin
                    miscompares++;
                    $display("FAIL sequence mode=%0d i=%0d signal=%0d/%0d rms=%0d/%0d fault=%0d/%0d prev=%0d",
                             m, i, sig_o, m_sig, rms_o, m_rms, fault_o, m_fault, prev);
                end
            end
            vectors++;
            if (fault_o !== 2'(m)) begin
                miscompares++;
                $display("FAIL sequence_final fault=%0d required %0d", fault_o, m);
            end else
                $display("sequence step mode=%0d fault=%0d rms=%0d", m, fault_o, rms_o);
            prev = 2'(m);
        end
    endtask

    task automatic test_async_reset();
        int skip;
        skip = 10 + int'($urandom_range(0, 40));
        for (int i = 0; i < skip; i++) step(2'b11);
        // Assert between edges and look before the next edge arrives.
        rst = 1'b1;
        #2;
        vectors++;
        if (sig_o !== 16'sd0 || rms_o !== 32'd0 || fault_o !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset signal=%0d rms=%0d fault=%0d required 0/0/0",
                     sig_o, rms_o, fault_o);
        end else
            $display("async_reset after %0d extra cycles ok", skip);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 70; i++) begin
            step(2'b11);
            vectors++;
            if (sig_o !== 16'(m_sig) || rms_o !== 32'(m_rms) || fault_o !== m_fault) begin
                miscompares++;
                $display("FAIL post_reset n=%0d signal=%0d/%0d rms=%0d/%0d fault=%0d/%0d",
                         n, sig_o, m_sig, rms_o, m_rms, fault_o, m_fault);
            end
            if (i == 63) begin
                vectors++;
                if (rms_o !== 32'd0) begin
                    miscompares++;
                    $display("FAIL post_reset_early rms=%0d required 0", rms_o);
                end
            end
            if (i == 64) begin
                vectors++;
                if (!within2(longint'(rms_o), 2097152) || fault_o !== 2'b11) begin
                    miscompares++;
                    $display("FAIL post_reset_first rms=%0d fault=%0d required ~2097152/3",
                             rms_o, fault_o);
                end else
                    $display("post_reset_first rms=%0d fault=%0d", rms_o, fault_o);
            end
        end
    endtask

    // Random mode hopping checked cycle by cycle against the model.
    task automatic test_random_modes();
        logic [1:0] m;
        int len;
        for (int seg = 0; seg < 12; seg++) begin
            m   = 2'($urandom_range(0, 3));
            len = int'($urandom_range(5, 150));
            for (int i = 0; i < len; i++) begin
                step(m);
                vectors++;
                if (sig_o !== 16'(m_sig) || rms_o !== 32'(m_rms) || fault_o !== m_fault) begin
                    miscompares++;
                    $display("FAIL random seg=%0d n=%0d signal=%0d/%0d rms=%0d/%0d fault=%0d/%0d",
                             seg, n, sig_o, m_sig, rms_o, m_rms, fault_o, m_fault);
                end
            end
            $display("random seg=%0d mode=%0d len=%0d rms=%0d fault=%0d", seg, m, len, rms_o, fault_o);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int k = 0; k < 64; k++)
            lut[k] = int'($floor(1024.0 * $sin(2.0 * 3.14159265358979 * k / 64.0) + 0.5));
        model_reset();

        test_reset();
        test_healthy();
        test_mode(2'b01, 655360, 0, 0);
        test_mode(2'b10, 1179648, 1536, -1536);
        test_mode(2'b11, 2097152, 2048, -2048);
        test_sequence();
        test_async_reset();
        test_random_modes();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
